// File: rtl/pulse_split_if.sv
// Event-source / lane-consumer bundle for pulse_split: adds in, per-lane pulses and pending count out.
interface pulse_split_if #(
   parameter int OUTPUT_WIDTH = 2,
   parameter int COUNT_WIDTH  = 4
);
   logic                    pulse_in;
   logic [COUNT_WIDTH-1:0]  count_in;
   logic                    count_valid;
   logic [OUTPUT_WIDTH-1:0] out_enable;
   logic [OUTPUT_WIDTH-1:0] pulse_out;
   logic [COUNT_WIDTH-1:0]  count_out;
   logic                    overflow;

   modport master (
      output pulse_in, count_in, count_valid, out_enable,
      input  pulse_out, count_out, overflow
   );

   modport slave (
      input  pulse_in, count_in, count_valid, out_enable,
      output pulse_out, count_out, overflow
   );
endinterface

// File: rtl/pulse_split.sv
// Pulse distributor: pending-event counter drained one pulse/cycle round-robin over enabled lanes.
// Add->count_out 1 cycle, add->pulse 2 cycles; no backpressure. PULSE_SPLIT_SATURATE_EN selects saturate+overflow vs wrap.
module pulse_split #(
   parameter int OUTPUT_WIDTH = 2,
   parameter int COUNT_WIDTH  = 4
) (
   input logic       clk,
   input logic       rst,
   pulse_split_if.slave bus
);
   localparam int PTR_W = (OUTPUT_WIDTH > 1) ? $clog2(OUTPUT_WIDTH) : 1;
   localparam int SUM_W = COUNT_WIDTH + 2;

   logic [COUNT_WIDTH-1:0]  pending_q, pending_d;
   logic [PTR_W-1:0]        ptr_q, ptr_d;
   logic [PTR_W-1:0]        sel_idx;
   logic [OUTPUT_WIDTH-1:0] pulse_q, pulse_d;
   logic                    sel_found;
   logic                    issue;
   logic [SUM_W-1:0]        sum;
   int                      lane;

   // Scan lanes starting at the pointer; first enabled one wins.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      lane      = 0;
      for (int i = 0; i < OUTPUT_WIDTH; i++) begin
         lane = (int'(ptr_q) + i) % OUTPUT_WIDTH;
         if (!sel_found && bus.out_enable[lane]) begin
            sel_found = 1'b1;
            sel_idx   = PTR_W'(lane);
         end
      end
   end

   always_comb begin
      issue   = (pending_q != '0) && sel_found;
      pulse_d = '0;
      ptr_d   = ptr_q;
      if (issue) begin
         pulse_d[sel_idx] = 1'b1;
         ptr_d = (sel_idx == PTR_W'(OUTPUT_WIDTH - 1)) ? '0 : sel_idx + PTR_W'(1);
      end
      // Issue is only possible with pending > 0, so the subtraction never underflows.
      sum = SUM_W'(pending_q) - SUM_W'(issue) + SUM_W'(bus.pulse_in)
          + (bus.count_valid ? SUM_W'(bus.count_in) : '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q <= '0;
         ptr_q     <= '0;
         pulse_q   <= '0;
      end else begin
         pending_q <= pending_d;
         ptr_q     <= ptr_d;
         pulse_q   <= pulse_d;
      end
   end

`ifdef PULSE_SPLIT_SATURATE_EN
   localparam logic [SUM_W-1:0] SAT_MAX = {2'b00, {COUNT_WIDTH{1'b1}}};

   logic overflow_q, overflow_d;

   always_comb begin
      pending_d  = sum[COUNT_WIDTH-1:0];
      overflow_d = 1'b0;
      if (sum > SAT_MAX) begin
         pending_d  = '1;
         overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) overflow_q <= 1'b0;
      else     overflow_q <= overflow_d;
   end

   assign bus.overflow = overflow_q;
`else
   logic unused_sum_hi;

   always_comb begin
      pending_d = sum[COUNT_WIDTH-1:0];
   end

   assign unused_sum_hi = ^sum[SUM_W-1:COUNT_WIDTH];
   assign bus.overflow  = 1'b0;
`endif

   assign bus.pulse_out = pulse_q;
   assign bus.count_out = pending_q;
endmodule

// File: tb/tb_pulse_split.sv
// Directed bench for pulse_split: a 2-lane and a 4-lane instance, each scenario in its own task.
module tb_pulse_split;
   logic clk;
   logic rst;
   int   checks;
   int   errors;

   pulse_split_if #(.OUTPUT_WIDTH(2), .COUNT_WIDTH(4)) bus_a ();
   pulse_split_if #(.OUTPUT_WIDTH(4), .COUNT_WIDTH(4)) bus_b ();

   pulse_split #(.OUTPUT_WIDTH(2), .COUNT_WIDTH(4)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
   pulse_split #(.OUTPUT_WIDTH(4), .COUNT_WIDTH(4)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs set before tick are applied on that edge; outputs read after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus_a.pulse_in = 1'b0; bus_a.count_in = '0; bus_a.count_valid = 1'b0; bus_a.out_enable = '0;
      bus_b.pulse_in = 1'b0; bus_b.count_in = '0; bus_b.count_valid = 1'b0; bus_b.out_enable = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (bus_a.count_out !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bus_a.count_out); end
      checks++;
      if (bus_a.pulse_out !== 2'b00) begin errors++; $display("FAIL reset_pulse got %b want 00", bus_a.pulse_out); end
      checks++;
      if (bus_a.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", bus_a.overflow); end
      checks++;
      if (bus_b.pulse_out !== 4'b0000) begin errors++; $display("FAIL reset_pulse_b got %b want 0000", bus_b.pulse_out); end
   endtask

   task automatic test_basic();
      do_reset();
      bus_a.out_enable = 2'b11;
      bus_a.pulse_in = 1'b1;
      tick();
      bus_a.pulse_in = 1'b0;
      checks++;
      if (bus_a.count_out !== 4'd1) begin errors++; $display("FAIL basic_count1 got %0d want 1", bus_a.count_out); end
      checks++;
      if (bus_a.pulse_out !== 2'b00) begin errors++; $display("FAIL basic_pulse1 got %b want 00", bus_a.pulse_out); end
      tick();
      checks++;
      if (bus_a.pulse_out !== 2'b01) begin errors++; $display("FAIL basic_pulse2 got %b want 01", bus_a.pulse_out); end
      checks++;
      if (bus_a.count_out !== 4'd0) begin errors++; $display("FAIL basic_count2 got %0d want 0", bus_a.count_out); end
      tick();
      checks++;
      if (bus_a.pulse_out !== 2'b00) begin errors++; $display("FAIL basic_pulse3 got %b want 00", bus_a.pulse_out); end
   endtask

   task automatic test_bulk_round_robin();
      logic [1:0] exp_p [5];
      exp_p = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
      do_reset();
      bus_a.out_enable = 2'b11;
      bus_a.count_valid = 1'b1;
      bus_a.count_in = 4'd5;
      tick();
      bus_a.count_valid = 1'b0;
      checks++;
      if (bus_a.count_out !== 4'd5) begin errors++; $display("FAIL bulk_load got %0d want 5", bus_a.count_out); end
      for (int k = 0; k < 5; k++) begin
         tick();
         checks++;
         if (bus_a.pulse_out !== exp_p[k]) begin errors++; $display("FAIL bulk_pulse[%0d] got %b want %b", k, bus_a.pulse_out, exp_p[k]); end
         checks++;
         if (bus_a.count_out !== 4'(4 - k)) begin errors++; $display("FAIL bulk_count[%0d] got %0d want %0d", k, bus_a.count_out, 4 - k); end
      end
      tick();
      checks++;
      if (bus_a.pulse_out !== 2'b00) begin errors++; $display("FAIL bulk_drained got %b want 00", bus_a.pulse_out); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      bus_a.out_enable = 2'b10;
      bus_a.count_valid = 1'b1;
      bus_a.count_in = 4'd2;
      tick();
      bus_a.count_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         tick();
         checks++;
         if (bus_a.pulse_out !== 2'b10) begin errors++; $display("FAIL b2b_pulse[%0d] got %b want 10", k, bus_a.pulse_out); end
      end
      checks++;
      if (bus_a.count_out !== 4'd0) begin errors++; $display("FAIL b2b_count got %0d want 0", bus_a.count_out); end
   endtask

   task automatic test_mask_skip();
      logic [3:0] exp_p [4];
      exp_p = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
      do_reset();
      bus_b.out_enable = 4'b1010;
      bus_b.count_valid = 1'b1;
      bus_b.count_in = 4'd6;
      tick();
      bus_b.count_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         tick();
         checks++;
         if (bus_b.pulse_out !== exp_p[k]) begin errors++; $display("FAIL mask_pre[%0d] got %b want %b", k, bus_b.pulse_out, exp_p[k]); end
      end
      bus_b.out_enable = 4'b0000;
      for (int k = 0; k < 2; k++) begin
         tick();
         checks++;
         if (bus_b.pulse_out !== 4'b0000) begin errors++; $display("FAIL mask_stall_pulse[%0d] got %b want 0000", k, bus_b.pulse_out); end
         checks++;
         if (bus_b.count_out !== 4'd4) begin errors++; $display("FAIL mask_stall_count[%0d] got %0d want 4", k, bus_b.count_out); end
      end
      bus_b.out_enable = 4'b1010;
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++;
         if (bus_b.pulse_out !== exp_p[k]) begin errors++; $display("FAIL mask_post[%0d] got %b want %b", k, bus_b.pulse_out, exp_p[k]); end
         checks++;
         if (bus_b.count_out !== 4'(3 - k)) begin errors++; $display("FAIL mask_count[%0d] got %0d want %0d", k, bus_b.count_out, 3 - k); end
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      bus_a.count_valid = 1'b1;
      bus_a.count_in = 4'd3;
      tick();
      checks++;
      if (bus_a.count_out !== 4'd3) begin errors++; $display("FAIL simul_load got %0d want 3", bus_a.count_out); end
      bus_a.out_enable = 2'b11;
      bus_a.pulse_in = 1'b1;
      bus_a.count_in = 4'd2;
      tick();
      bus_a.pulse_in = 1'b0;
      bus_a.count_valid = 1'b0;
      checks++;
      if (bus_a.count_out !== 4'd5) begin errors++; $display("FAIL simul_count got %0d want 5", bus_a.count_out); end
      checks++;
      if (bus_a.pulse_out !== 2'b01) begin errors++; $display("FAIL simul_pulse got %b want 01", bus_a.pulse_out); end
   endtask

   task automatic test_overflow();
      logic [3:0] exp_cnt;
      logic       exp_ovf;
`ifdef PULSE_SPLIT_SATURATE_EN
      exp_cnt = 4'd15;
      exp_ovf = 1'b1;
`else
      exp_cnt = 4'd3;
      exp_ovf = 1'b0;
`endif
      do_reset();
      bus_a.count_valid = 1'b1;
      bus_a.count_in = 4'd14;
      tick();
      checks++;
      if (bus_a.count_out !== 4'd14) begin errors++; $display("FAIL ovf_load got %0d want 14", bus_a.count_out); end
      bus_a.count_in = 4'd4;
      bus_a.pulse_in = 1'b1;
      tick();
      bus_a.count_valid = 1'b0;
      bus_a.pulse_in = 1'b0;
      checks++;
      if (bus_a.count_out !== exp_cnt) begin errors++; $display("FAIL ovf_count got %0d want %0d", bus_a.count_out, exp_cnt); end
      checks++;
      if (bus_a.overflow !== exp_ovf) begin errors++; $display("FAIL ovf_flag got %b want %b", bus_a.overflow, exp_ovf); end
      tick();
      checks++;
      if (bus_a.overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", bus_a.overflow); end
      checks++;
      if (bus_a.count_out !== exp_cnt) begin errors++; $display("FAIL ovf_hold got %0d want %0d", bus_a.count_out, exp_cnt); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      bus_a.out_enable = 2'b11;
      bus_a.count_valid = 1'b1;
      bus_a.count_in = 4'd9;
      tick();
      bus_a.count_valid = 1'b0;
      repeat (3) tick();
      checks++;
      if (bus_a.count_out !== 4'd6) begin errors++; $display("FAIL rstmid_pre got %0d want 6", bus_a.count_out); end
      rst = 1'b1;
      bus_a.pulse_in = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (bus_a.count_out !== 4'd0) begin errors++; $display("FAIL rstmid_count got %0d want 0", bus_a.count_out); end
      checks++;
      if (bus_a.pulse_out !== 2'b00) begin errors++; $display("FAIL rstmid_pulse got %b want 00", bus_a.pulse_out); end
      tick();
      bus_a.pulse_in = 1'b0;
      checks++;
      if (bus_a.count_out !== 4'd1) begin errors++; $display("FAIL rstmid_add got %0d want 1", bus_a.count_out); end
      tick();
      checks++;
      if (bus_a.pulse_out !== 2'b01) begin errors++; $display("FAIL rstmid_lane0 got %b want 01", bus_a.pulse_out); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_basic();
      test_bulk_round_robin();
      test_back_to_back();
      test_mask_skip();
      test_simultaneous();
      test_overflow();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/pulse_split.md
# pulse_split

Pulse distributor: accepts single event pulses and bulk event counts, holds them in a pending counter, and issues them one per cycle as single-cycle pulses spread round-robin across `OUTPUT_WIDTH` enabled outputs. It is the fan-out counterpart of the team's pulse merge/count logic. It sits where one aggregated event source must drive several per-lane consumers, such as interrupt or doorbell lanes.

## Interface
- `OUTPUT_WIDTH`, default 2: number of output lanes; must be ≥1.
- `COUNT_WIDTH`, default 4: width of the pending counter and `count_in`; must be ≥1.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `pulse_in`  in  1  adds 1 pending event when high.
- `count_in`  in  COUNT_WIDTH  bulk event count; added when `count_valid` is high.
- `count_valid`  in  1  qualifies `count_in`.
- `out_enable`  in  OUTPUT_WIDTH  per-lane enable mask; disabled lanes never pulse.
- `pulse_out`  out  OUTPUT_WIDTH  registered, one-hot or zero, one pulse per issued event.
- `count_out`  out  COUNT_WIDTH  current pending count (`pending_reg`).
- `overflow`  out  1  registered single-cycle flag: events were dropped this update.

## Operation
- **State:** `pending_reg` (COUNT_WIDTH bits), `ptr_reg` (round-robin pointer, $clog2(OUTPUT_WIDTH) bits, minimum 1), `pulse_out_reg`, `overflow_reg`.
- **Issue condition:** `pending_reg > 0` and `out_enable != 0`.
- **Lane selection:**
  - Scan lanes `ptr_reg`, `ptr_reg+1`, … modulo OUTPUT_WIDTH.
  - The first lane with `out_enable` high is selected.
  - `pulse_out_next` = one-hot of the selected lane.
  - `ptr_next` = selected+1, wrapping to 0 after OUTPUT_WIDTH-1.
- **No issue:** `pulse_out_next` = 0 and the pointer holds.
- **Pending update:**
  - sum = `pending_reg` − issue + `pulse_in` + (`count_valid` ? `count_in` : 0).
  - The sum is computed in COUNT_WIDTH+2 bits.
  - The result is clamped per the Configuration section.
- **Simultaneous events:** an issue and any number of adds in the same cycle are all applied in the same update.
  - Example: pending=1 with `pulse_in`=1 and an issue gives pending=1.
- **Mask changes:** `out_enable` is sampled only in the issue cycle. Masking all lanes stalls issuing; pending keeps accumulating.
- **Reset:** pending=0, ptr=0, `pulse_out`=0, `overflow`=0.
  - Reset asserted mid-operation discards all pending events.
  - Inputs in the reset cycle are ignored.

## Timing
- **Latency:** an event added in cycle N raises `count_out` in N+1. If it is the only pending event and a lane is enabled, the `pulse_out` bit is high in cycle N+2.
- **Throughput:** one pulse per cycle maximum, aggregated across all lanes. A pending count of K with a constant enable mask produces K pulses on K consecutive cycles.
- **Output width:** each `pulse_out` bit is high for exactly one cycle per issued event. The same lane may pulse on back-to-back cycles only when it is the sole enabled lane.
- **Count/pulse alignment:** `count_out` and `pulse_out` update on the same edge. The issue that produced `pulse_out` is already subtracted from `count_out`.

## Configuration
- **Macro:** `PULSE_SPLIT_SATURATE_EN`.
- **Defined:**
  - The sum saturates at 2^COUNT_WIDTH−1.
  - `overflow` pulses high for one cycle, registered, whenever the unclamped sum exceeded that maximum.
- **Undefined:**
  - The sum wraps modulo 2^COUNT_WIDTH.
  - `overflow` is tied to 0.

## Test plan
- **Basic issue:** reset, `out_enable`=2'b11, one `pulse_in` in cycle 0.
  - `count_out`=1 in cycle 1, `pulse_out`=2'b01 in cycle 2, `count_out`=0 in cycle 2.
- **Bulk and round-robin:** `count_valid`=1, `count_in`=5, OUTPUT_WIDTH=2, all lanes enabled.
  - Five consecutive pulses: 01, 10, 01, 10, 01.
  - `count_out` goes 5, 4, 3, 2, 1, 0.
- **Mask skip:** OUTPUT_WIDTH=4, `out_enable`=4'b1010, pending=4.
  - Pulses 0010, 1000, 0010, 1000.
  - Set mask to 0 mid-stream: pulses stop and `count_out` holds.
- **Simultaneous add and issue:** pending=3, `pulse_in`=1 and `count_valid`=1 with `count_in`=2 during an issue.
  - Next `count_out`=5.
- **Overflow** (COUNT_WIDTH=4): pending=14, `count_in`=4 plus `pulse_in`=1, no lane enabled.
  - With the macro: `count_out`=15 and `overflow` high for exactly one cycle.
  - Without the macro: `count_out`=(14+5) mod 16=3 and `overflow`=0.
- **Reset mid-operation:** pending=9 while issuing; assert `rst` for one cycle.
  - Next cycle: `count_out`=0, `pulse_out`=0, pointer restarts at lane 0.
